// File: rtl/nn_seq_pkg.sv
// Shared types and instruction-field helpers for the nn_seq_router block.
// Optional feature macro: NN_SEQ_FEEDBACK_EN adds the feedback (FB) state.
package nn_seq_pkg;

  localparam int unsigned OpcW = 3;

  typedef enum logic [2:0] {
    OpNop    = 3'd0,
    OpLdIn   = 3'd1,
    OpLdW    = 3'd2,
    OpLdB    = 3'd3,
    OpAccW   = 3'd4,
    OpSwitch = 3'd5,
    OpRun    = 3'd6,
    OpRsvd   = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
`ifdef NN_SEQ_FEEDBACK_EN
    , StFb  = 2'd3
`endif
  } state_e;

  // Instruction word is {opcode, addr, data}.
  function automatic int unsigned instr_w(input int unsigned data_w, input int unsigned ch_w);
    return OpcW + ch_w + data_w;
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned opc_lsb(input int unsigned data_w, input int unsigned ch_w);
    return data_w + ch_w;
  endfunction

endpackage

// File: rtl/nn_seq_router_if.sv
// Bundles the instruction, load, result and output streams of nn_seq_router.
interface nn_seq_router_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NUM_CH = 2
) ();
  localparam int unsigned CH_W    = $clog2(NUM_CH);
  localparam int unsigned INSTR_W = nn_seq_pkg::instr_w(DATA_W, CH_W);

  logic                     instr_valid;
  logic                     instr_ready;
  logic [INSTR_W-1:0]       instr_data;
  logic [NUM_CH-1:0]        ld_in_vld;
  logic [NUM_CH-1:0]        ld_w_vld;
  logic                     ld_b_vld;
  logic [DATA_W-1:0]        ld_data;
  logic                     nn_start;
  logic                     accept_w;
  logic                     switch_out;
  logic [NUM_CH-1:0]        res_vld;
  logic [NUM_CH*DATA_W-1:0] res_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     busy;
  logic                     err_timeout;
  logic                     err_addr;

  // Router side.
  modport slave (
    input  instr_valid, instr_data, res_vld, res_data, out_ready,
    output instr_ready, ld_in_vld, ld_w_vld, ld_b_vld, ld_data, nn_start, accept_w,
           switch_out, out_valid, out_data, out_ch, busy, err_timeout, err_addr
  );

  // Host / datapath side.
  modport master (
    output instr_valid, instr_data, res_vld, res_data, out_ready,
    input  instr_ready, ld_in_vld, ld_w_vld, ld_b_vld, ld_data, nn_start, accept_w,
           switch_out, out_valid, out_data, out_ch, busy, err_timeout, err_addr
  );
endinterface

// File: rtl/nn_seq_capture.sv
// Per-channel result capture: first valid pulse per channel wins until cleared.
module nn_seq_capture #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NUM_CH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           cap_en,
  input  logic [NUM_CH-1:0]              res_vld,
  input  logic [NUM_CH*DATA_W-1:0]       res_data,
  input  logic [$clog2(NUM_CH)-1:0]      rd_idx,
  output logic [DATA_W-1:0]              rd_data,
  output logic                           all_done
);
  logic [NUM_CH-1:0]             flag_q, flag_d;
  logic [NUM_CH-1:0][DATA_W-1:0] res_q, res_d;

  // Capture each channel once; clear takes priority so a new pass starts empty.
  always_comb begin
    flag_d = flag_q;
    res_d  = res_q;
    if (clear) begin
      flag_d = '0;
    end else if (cap_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (res_vld[c] && !flag_q[c]) begin
          flag_d[c] = 1'b1;
          res_d[c]  = res_data[c*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Result registers and capture flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_q <= '0;
      res_q  <= '0;
    end else begin
      flag_q <= flag_d;
      res_q  <= res_d;
    end
  end

  assign all_done = &flag_q;
  assign rd_data  = res_q[rd_idx];
endmodule

// File: rtl/nn_seq_router.sv
// Instruction sequencer/router: decodes host instructions into one-cycle load strobes and
// pulses, runs a pass collecting every channel's result, then optionally streams them out.
// Optional feature macro: NN_SEQ_FEEDBACK_EN replays results as input loads (FB state).
module nn_seq_router
  import nn_seq_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic         clk,
  input logic         rst,
  nn_seq_router_if.slave bus
);
  localparam int unsigned     CH_W     = $clog2(NUM_CH);
  localparam int unsigned     CntW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CH_W:0]   NumChL   = (CH_W + 1)'(NUM_CH);
  localparam logic [CH_W-1:0] LastCh   = CH_W'(NUM_CH - 1);
  localparam logic [CntW-1:0] TimeoutL = CntW'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d, done_next;
  logic              drain_q, drain_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CH_W-1:0]   idx_q, idx_d;
  logic [NUM_CH-1:0] ld_in_q, ld_in_d, ld_w_q, ld_w_d;
  logic              ld_b_q, ld_b_d, start_q, start_d, acc_w_q, acc_w_d, switch_q, switch_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;
  logic              err_to_q, err_to_d, err_addr_q, err_addr_d;
  logic              ready_q;
  logic              cap_clear, all_done;
  logic [DATA_W-1:0] rd_data;
`ifdef NN_SEQ_FEEDBACK_EN
  logic              fb_q, fb_d;
`endif

  opcode_e           opc;
  logic [CH_W-1:0]   addr;
  logic [DATA_W-1:0] data;
  logic              accept;

  assign data   = bus.instr_data[DATA_W-1:0];
  assign addr   = bus.instr_data[addr_lsb(DATA_W) +: CH_W];
  assign opc    = opcode_e'(bus.instr_data[opc_lsb(DATA_W, CH_W) +: OpcW]);
  assign accept = bus.instr_valid && ready_q;

  nn_seq_capture #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH)
  ) u_capture (
    .clk      (clk),
    .rst      (rst),
    .clear    (cap_clear),
    .cap_en   (state_q == StRun),
    .res_vld  (bus.res_vld),
    .res_data (bus.res_data),
    .rd_idx   (idx_q),
    .rd_data  (rd_data),
    .all_done (all_done)
  );

  // Where a completed pass goes next.
  always_comb begin
    done_next = drain_q ? StDrain : StIdle;
`ifdef NN_SEQ_FEEDBACK_EN
    if (fb_q) done_next = StFb;
`endif
  end

  // Next-state, strobe and error logic; every strobe defaults low so pulses are one cycle.
  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    ld_in_d    = '0;
    ld_w_d     = '0;
    ld_b_d     = 1'b0;
    ld_data_d  = ld_data_q;
    start_d    = 1'b0;
    acc_w_d    = 1'b0;
    switch_d   = 1'b0;
    err_to_d   = err_to_q;
    err_addr_d = err_addr_q;
    cap_clear  = 1'b0;
`ifdef NN_SEQ_FEEDBACK_EN
    fb_d       = fb_q;
`endif
    case (state_q)
      StIdle: begin
        if (accept) begin
          case (opc)
            OpLdIn, OpLdW: begin
              ld_data_d = data;
              if ({1'b0, addr} >= NumChL) begin
                err_addr_d = 1'b1;
              end else if (opc == OpLdIn) begin
                ld_in_d[addr] = 1'b1;
              end else begin
                ld_w_d[addr] = 1'b1;
              end
            end
            OpLdB: begin
              ld_b_d    = 1'b1;
              ld_data_d = data;
            end
            OpAccW:   acc_w_d  = 1'b1;
            OpSwitch: switch_d = 1'b1;
            OpRun: begin
              start_d   = 1'b1;
              drain_d   = data[1];
`ifdef NN_SEQ_FEEDBACK_EN
              fb_d      = data[0];
`endif
              cap_clear = 1'b1;
              cnt_d     = '0;
              state_d   = StRun;
            end
            default: ;
          endcase
        end
      end
      StRun: begin
        if (all_done) begin
          idx_d   = '0;
          state_d = done_next;
        end else if (cnt_q == TimeoutL) begin
          err_to_d = 1'b1;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef NN_SEQ_FEEDBACK_EN
      StFb: begin
        ld_in_d[idx_q] = 1'b1;
        ld_data_d      = rd_data;
        if (idx_q == LastCh) begin
          idx_d   = '0;
          state_d = drain_q ? StDrain : StIdle;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
`endif
      StDrain: begin
        if (bus.out_ready) begin
          if (idx_q == LastCh) begin
            idx_d   = '0;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; ready tracks the state it will be in next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      drain_q    <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      ld_in_q    <= '0;
      ld_w_q     <= '0;
      ld_b_q     <= 1'b0;
      ld_data_q  <= '0;
      start_q    <= 1'b0;
      acc_w_q    <= 1'b0;
      switch_q   <= 1'b0;
      err_to_q   <= 1'b0;
      err_addr_q <= 1'b0;
      ready_q    <= 1'b0;
`ifdef NN_SEQ_FEEDBACK_EN
      fb_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      ld_in_q    <= ld_in_d;
      ld_w_q     <= ld_w_d;
      ld_b_q     <= ld_b_d;
      ld_data_q  <= ld_data_d;
      start_q    <= start_d;
      acc_w_q    <= acc_w_d;
      switch_q   <= switch_d;
      err_to_q   <= err_to_d;
      err_addr_q <= err_addr_d;
      ready_q    <= (state_d == StIdle);
`ifdef NN_SEQ_FEEDBACK_EN
      fb_q       <= fb_d;
`endif
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.ld_in_vld   = ld_in_q;
  assign bus.ld_w_vld    = ld_w_q;
  assign bus.ld_b_vld    = ld_b_q;
  assign bus.ld_data     = ld_data_q;
  assign bus.nn_start    = start_q;
  assign bus.accept_w    = acc_w_q;
  assign bus.switch_out  = switch_q;
  assign bus.out_valid   = (state_q == StDrain);
  assign bus.out_data    = (state_q == StDrain) ? rd_data : '0;
  assign bus.out_ch      = (state_q == StDrain) ? idx_q : '0;
  assign bus.busy        = (state_q != StIdle);
  assign bus.err_timeout = err_to_q;
  assign bus.err_addr    = err_addr_q;
endmodule
